uart_tx_datapath: RTL and testbench

UART transmit datapath that consumes the Tx controller's `Ser_EN` and `Mux_control` outputs and returns `Ser_done` to it. It contains:
- a parallel-load data register and LSB-first shift serializer with bit counter;
- a parity generator;
- a registered 4:1 line mux that drives the serial output `TX_OUT`.

It sits directly downstream of the Tx control FSM and is the last stage before the pin.

---
 rtl/uart_tx_datapath.sv | 88 ++++++++
 tb/tb_uart_tx_datapath.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: parallel load, LSB-first serializer with bit
// counter, parity generator and a registered line mux driving TX_OUT.
// The Tx controller owns all sequencing. This block only tracks the bit
// position and reports the last data bit through Ser_done.
module uart_tx_datapath #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_valid,
    input  logic                  Busy,
    input  logic                  Parity_Type,
    input  logic                  Ser_EN,
    input  logic [1:0]            Mux_control,
    output logic                  Ser_done,
    output logic                  TX_OUT
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_IDLE   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  parity_bit;
    logic                  load_en;
    logic                  ser_data;

    // A load request while the controller is busy is dropped entirely.
    assign load_en  = Data_valid && !Busy;
    assign ser_data = shift_reg[0];

    // Done is flagged while the last data bit is on the serializer output.
    assign Ser_done = Ser_EN && (bit_cnt == CNT_LAST);

    // Data register: load captures the byte, shift moves the next bit to bit 0.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            shift_reg <= '0;
        end else if (load_en) begin
            shift_reg <= P_DATA;
        end else if (Ser_EN) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    // Bit counter: wraps after the last bit so stray enables restart the count.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            bit_cnt <= '0;
        end else if (load_en) begin
            bit_cnt <= '0;
        end else if (Ser_EN) begin
            bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    // Parity is computed from the byte at load time and held for the frame,
    // so later changes to P_DATA or Parity_Type cannot disturb it.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            parity_bit <= 1'b0;
        end else if (load_en) begin
            parity_bit <= Parity_Type ? ~^P_DATA : ^P_DATA;
        end
    end

    // Line mux: registered so the pin is glitch-free and lags the select by one cycle.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            TX_OUT <= 1'b1;
        end else begin
            unique case (Mux_control)
                SEL_START:  TX_OUT <= 1'b0;
                SEL_IDLE:   TX_OUT <= 1'b1;
                SEL_DATA:   TX_OUT <= ser_data;
                SEL_PARITY: TX_OUT <= parity_bit;
                default:    TX_OUT <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed bench for uart_tx_datapath; the bench plays the Tx controller.
module tb_uart_tx_datapath;

    logic       CLK;
    logic       Reset;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       Busy;
    logic       Parity_Type;
    logic       Ser_EN;
    logic [1:0] Mux_control;
    logic       Ser_done;
    logic       TX_OUT;

    int n_total;
    int n_bad;

    uart_tx_datapath #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .P_DATA      (P_DATA),
        .Data_valid  (Data_valid),
        .Busy        (Busy),
        .Parity_Type (Parity_Type),
        .Ser_EN      (Ser_EN),
        .Mux_control (Mux_control),
        .Ser_done    (Ser_done),
        .TX_OUT      (TX_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Compare one observed value against its expected value.
    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive just after the rising edge, return at the falling edge.
    task automatic step(input logic dv, input logic [7:0] pd, input logic bsy,
                        input logic pt, input logic sen, input logic [1:0] mux);
        @(posedge CLK);
        #1;
        Data_valid  = dv;
        P_DATA      = pd;
        Busy        = bsy;
        Parity_Type = pt;
        Ser_EN      = sen;
        Mux_control = mux;
        @(negedge CLK);
    endtask

    // Full frame as the controller would run it; load cycle is cycle 0.
    // exp lists TX_OUT for cycles 1..10 left to right (start, 8 data bits, parity).
    task automatic frame(input string tag, input logic [7:0] d, input logic pt,
                         input logic [9:0] exp, input logic noise);
        step(1'b1, d, 1'b0, pt, 1'b0, 2'b00);
        chk_eq({tag, "_c0_tx"}, 32'(TX_OUT), 32'd1);
        chk_eq({tag, "_c0_done"}, 32'(Ser_done), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            if (noise)
                step(k == 4, 8'hFF, 1'b1, ~pt, 1'b1, 2'b10);
            else
                step(1'b0, ~d, 1'b1, ~pt, 1'b1, 2'b10);
            chk_eq($sformatf("%s_c%0d_tx", tag, k), 32'(TX_OUT), 32'(exp[10-k]));
            chk_eq($sformatf("%s_c%0d_done", tag, k), 32'(Ser_done), 32'(k == 8));
        end
        step(noise, 8'hFF, 1'b1, ~pt, 1'b0, 2'b11);
        chk_eq({tag, "_c9_tx"}, 32'(TX_OUT), 32'(exp[1]));
        chk_eq({tag, "_c9_done"}, 32'(Ser_done), 32'd0);
        step(1'b0, 8'h00, 1'b1, pt, 1'b0, 2'b01);
        chk_eq({tag, "_c10_par"}, 32'(TX_OUT), 32'(exp[0]));
    endtask

    task automatic idle_chk(input string tag);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01);
        chk_eq(tag, 32'(TX_OUT), 32'd1);
    endtask

    initial begin
        logic [7:0] a5;
        n_total     = 0;
        n_bad       = 0;
        Reset       = 1'b0;
        P_DATA      = 8'h00;
        Data_valid  = 1'b0;
        Busy        = 1'b0;
        Parity_Type = 1'b0;
        Ser_EN      = 1'b0;
        Mux_control = 2'b01;
        a5          = 8'hA5;

        #12;
        chk_eq("rst_tx", 32'(TX_OUT), 32'd1);
        chk_eq("rst_done", 32'(Ser_done), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        idle_chk("idle_tx");

        // Even parity 0xA5: 0,1,0,1,0,0,1,0,1,0 then stop
        frame("even_a5", 8'hA5, 1'b0, 10'b0_10100101_0, 1'b0);
        idle_chk("even_a5_stop");

        // Odd parity
        frame("odd_01", 8'h01, 1'b1, 10'b0_10000000_0, 1'b0);
        idle_chk("odd_01_stop");
        frame("odd_00", 8'h00, 1'b1, 10'b0_00000000_1, 1'b0);
        idle_chk("odd_00_stop");

        // Load attempts of 0xFF while busy must not disturb a 0x3C frame
        frame("busy_3c", 8'h3C, 1'b0, 10'b0_00111100_0, 1'b1);
        idle_chk("busy_3c_stop");

        // Back-to-back: second load lands in the stop cycle of the first frame
        frame("b2b_55", 8'h55, 1'b0, 10'b0_10101010_0, 1'b0);
        frame("b2b_0f", 8'h0F, 1'b0, 10'b0_11110000_0, 1'b0);
        idle_chk("b2b_0f_stop");

        // Reset asserted mid-frame while data bit 3 is on the line
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int k = 1; k <= 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'b10);
        chk_eq("pre_rst_bit2", 32'(TX_OUT), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'b10);
        chk_eq("pre_rst_bit3", 32'(TX_OUT), 32'd0);
        Reset = 1'b0;
        #1;
        chk_eq("midrst_tx", 32'(TX_OUT), 32'd1);
        chk_eq("midrst_done", 32'(Ser_done), 32'd0);
        Ser_EN      = 1'b0;
        Mux_control = 2'b01;
        Busy        = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) idle_chk($sformatf("post_rst_tx%0d", k));

        // Counter wrap: 16 consecutive enables after loading 0xA5
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 2'b01);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'b10);
            chk_eq($sformatf("wrap_done%0d", k), 32'(Ser_done), 32'(k == 8 || k == 16));
            if (k >= 2 && k <= 9)
                chk_eq($sformatf("wrap_bit%0d", k), 32'(TX_OUT), 32'(a5[k-2]));
            else if (k >= 10)
                chk_eq($sformatf("wrap_zero%0d", k), 32'(TX_OUT), 32'd0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01);
        chk_eq("wrap_tail_zero", 32'(TX_OUT), 32'd0);
        chk_eq("wrap_tail_done", 32'(Ser_done), 32'd0);
        idle_chk("wrap_idle");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
